// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier controller: two independent FSMs with time-of-day entry window, vacancy admission,
// pass/timeout handling and close-hold re-arm delay. Optional PARKING_GATE_STATS_EN adds a saturating denial counter.
module parking_gate_ctrl #(
    parameter int GATE_TIMEOUT = 1000,
    parameter int CLOSE_HOLD   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] timer,
    input  logic        entry_req,
    input  logic        entry_is_uni,
    input  logic        entry_pass,
    input  logic        exit_req,
    input  logic        exit_is_uni,
    input  logic        exit_pass,
    input  logic        uni_is_vacated_space,
    input  logic        is_vacated_space,
    output logic        entry_gate_open,
    output logic        exit_gate_open,
    output logic        car_entered,
    output logic        is_uni_car_enterd,
    output logic        car_exited,
    output logic        is_uni_car_exited,
    output logic        entry_denied
`ifdef PARKING_GATE_STATS_EN
    ,
    output logic [15:0] denied_count
`endif
);

    localparam int MAXV = (GATE_TIMEOUT > CLOSE_HOLD) ? GATE_TIMEOUT : CLOSE_HOLD;
    localparam int CW   = (MAXV < 1) ? 1 : $clog2(MAXV + 1);
    // Last counter value of each phase; zero-length settings degrade to one cycle.
    localparam logic [CW-1:0] TO_LAST   = CW'((GATE_TIMEOUT > 0) ? GATE_TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] HOLD_LAST = CW'((CLOSE_HOLD > 0) ? CLOSE_HOLD - 1 : 0);

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_OPEN = 2'd1,
        E_HOLD = 2'd2,
        E_DENY = 2'd3
    } entry_state_t;

    typedef enum logic [1:0] {
        X_IDLE = 2'd0,
        X_OPEN = 2'd1,
        X_HOLD = 2'd2
    } exit_state_t;

    entry_state_t  e_state_q, e_state_d;
    logic [CW-1:0] e_cnt_q, e_cnt_d;
    logic          e_tag_q, e_tag_d;
    logic          entry_gate_open_q, entry_gate_open_d;
    logic          car_entered_q, car_entered_d;
    logic          uni_entered_q, uni_entered_d;
    logic          entry_denied_q, entry_denied_d;

    exit_state_t   x_state_q, x_state_d;
    logic [CW-1:0] x_cnt_q, x_cnt_d;
    logic          x_tag_q, x_tag_d;
    logic          exit_gate_open_q, exit_gate_open_d;
    logic          car_exited_q, car_exited_d;
    logic          uni_exited_q, uni_exited_d;

    logic window_open;
    logic admit;

    assign window_open = (timer >= 32'd480) && (timer < 32'd1200);
    assign admit       = window_open &&
                         (is_vacated_space || (entry_is_uni && uni_is_vacated_space));

    always_comb begin
        e_state_d      = e_state_q;
        e_cnt_d        = e_cnt_q;
        e_tag_d        = e_tag_q;
        car_entered_d  = 1'b0;
        uni_entered_d  = 1'b0;
        entry_denied_d = 1'b0;
        case (e_state_q)
            E_IDLE: begin
                if (entry_req) begin
                    if (admit) begin
                        e_state_d = E_OPEN;
                        e_tag_d   = entry_is_uni;
                    end else begin
                        e_state_d      = E_DENY;
                        entry_denied_d = 1'b1;
                    end
                end
            end
            E_OPEN: begin
                // A pass wins over a coincident timeout or window close.
                if (entry_pass) begin
                    e_state_d     = E_HOLD;
                    car_entered_d = 1'b1;
                    uni_entered_d = e_tag_q;
                end else if ((e_cnt_q >= TO_LAST) || !window_open) begin
                    e_state_d = E_HOLD;
                end else begin
                    e_cnt_d = e_cnt_q + 1'b1;
                end
            end
            E_HOLD: begin
                if ((e_cnt_q >= HOLD_LAST) && !entry_req) begin
                    e_state_d = E_IDLE;
                end else if (e_cnt_q < HOLD_LAST) begin
                    e_cnt_d = e_cnt_q + 1'b1;
                end
            end
            E_DENY: begin
                if (!entry_req) begin
                    e_state_d = E_IDLE;
                end
            end
            default: e_state_d = E_IDLE;
        endcase
        if (e_state_d != e_state_q) begin
            e_cnt_d = '0;
        end
        entry_gate_open_d = (e_state_d == E_OPEN);
    end

    always_comb begin
        x_state_d     = x_state_q;
        x_cnt_d       = x_cnt_q;
        x_tag_d       = x_tag_q;
        car_exited_d  = 1'b0;
        uni_exited_d  = 1'b0;
        case (x_state_q)
            X_IDLE: begin
                if (exit_req) begin
                    x_state_d = X_OPEN;
                    x_tag_d   = exit_is_uni;
                end
            end
            X_OPEN: begin
                if (exit_pass) begin
                    x_state_d    = X_HOLD;
                    car_exited_d = 1'b1;
                    uni_exited_d = x_tag_q;
                end else if (x_cnt_q >= TO_LAST) begin
                    x_state_d = X_HOLD;
                end else begin
                    x_cnt_d = x_cnt_q + 1'b1;
                end
            end
            X_HOLD: begin
                if ((x_cnt_q >= HOLD_LAST) && !exit_req) begin
                    x_state_d = X_IDLE;
                end else if (x_cnt_q < HOLD_LAST) begin
                    x_cnt_d = x_cnt_q + 1'b1;
                end
            end
            default: x_state_d = X_IDLE;
        endcase
        if (x_state_d != x_state_q) begin
            x_cnt_d = '0;
        end
        exit_gate_open_d = (x_state_d == X_OPEN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_state_q         <= E_IDLE;
            e_cnt_q           <= '0;
            e_tag_q           <= 1'b0;
            entry_gate_open_q <= 1'b0;
            car_entered_q     <= 1'b0;
            uni_entered_q     <= 1'b0;
            entry_denied_q    <= 1'b0;
        end else begin
            e_state_q         <= e_state_d;
            e_cnt_q           <= e_cnt_d;
            e_tag_q           <= e_tag_d;
            entry_gate_open_q <= entry_gate_open_d;
            car_entered_q     <= car_entered_d;
            uni_entered_q     <= uni_entered_d;
            entry_denied_q    <= entry_denied_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_state_q        <= X_IDLE;
            x_cnt_q          <= '0;
            x_tag_q          <= 1'b0;
            exit_gate_open_q <= 1'b0;
            car_exited_q     <= 1'b0;
            uni_exited_q     <= 1'b0;
        end else begin
            x_state_q        <= x_state_d;
            x_cnt_q          <= x_cnt_d;
            x_tag_q          <= x_tag_d;
            exit_gate_open_q <= exit_gate_open_d;
            car_exited_q     <= car_exited_d;
            uni_exited_q     <= uni_exited_d;
        end
    end

    assign entry_gate_open   = entry_gate_open_q;
    assign exit_gate_open    = exit_gate_open_q;
    assign car_entered       = car_entered_q;
    assign is_uni_car_enterd = uni_entered_q;
    assign car_exited        = car_exited_q;
    assign is_uni_car_exited = uni_exited_q;
    assign entry_denied      = entry_denied_q;

`ifdef PARKING_GATE_STATS_EN
    logic [15:0] denied_count_q, denied_count_d;

    // Counts in step with the denial pulse itself, saturating at all-ones.
    always_comb begin
        denied_count_d = denied_count_q;
        if (entry_denied_d && (denied_count_q != 16'hFFFF)) begin
            denied_count_d = denied_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            denied_count_q <= 16'd0;
        end else begin
            denied_count_q <= denied_count_d;
        end
    end

    assign denied_count = denied_count_q;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl (GATE_TIMEOUT=8, CLOSE_HOLD=4); inputs driven and outputs sampled on falling edges.
module tb_parking_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] timer;
    logic        entry_req, entry_is_uni, entry_pass;
    logic        exit_req, exit_is_uni, exit_pass;
    logic        uni_is_vacated_space, is_vacated_space;
    logic        entry_gate_open, exit_gate_open;
    logic        car_entered, is_uni_car_enterd;
    logic        car_exited, is_uni_car_exited;
    logic        entry_denied;
`ifdef PARKING_GATE_STATS_EN
    logic [15:0] denied_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    parking_gate_ctrl #(.GATE_TIMEOUT(8), .CLOSE_HOLD(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .timer                (timer),
        .entry_req            (entry_req),
        .entry_is_uni         (entry_is_uni),
        .entry_pass           (entry_pass),
        .exit_req             (exit_req),
        .exit_is_uni          (exit_is_uni),
        .exit_pass            (exit_pass),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space),
        .entry_gate_open      (entry_gate_open),
        .exit_gate_open       (exit_gate_open),
        .car_entered          (car_entered),
        .is_uni_car_enterd    (is_uni_car_enterd),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited),
        .entry_denied         (entry_denied)
`ifdef PARKING_GATE_STATS_EN
        ,
        .denied_count         (denied_count)
`endif
    );

    task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        timer = 32'd600;
        entry_req = 0; entry_is_uni = 0; entry_pass = 0;
        exit_req = 0; exit_is_uni = 0; exit_pass = 0;
        uni_is_vacated_space = 0; is_vacated_space = 0;
        step(2);
        chk("rst_entry_gate", {31'd0, entry_gate_open}, 32'd0);
        chk("rst_exit_gate", {31'd0, exit_gate_open}, 32'd0);
        chk("rst_strobes", {27'd0, car_entered, is_uni_car_enterd, car_exited, is_uni_car_exited, entry_denied}, 32'd0);
`ifdef PARKING_GATE_STATS_EN
        chk("rst_denied_count", {16'd0, denied_count}, 32'd0);
`endif
        rst = 1'b0;

        // Non-uni car admitted on free-car vacancy, passes 3 cycles after opening.
        is_vacated_space = 1; entry_req = 1; entry_is_uni = 0;
        step(1);
        chk("t1_gate_open", {31'd0, entry_gate_open}, 32'd1);
        chk("t1_no_strobe", {31'd0, car_entered}, 32'd0);
        step(2);
        chk("t1_gate_still_open", {31'd0, entry_gate_open}, 32'd1);
        entry_pass = 1; entry_req = 0;
        step(1);
        chk("t1_car_entered", {31'd0, car_entered}, 32'd1);
        chk("t1_tag", {31'd0, is_uni_car_enterd}, 32'd0);
        chk("t1_gate_dropped", {31'd0, entry_gate_open}, 32'd0);
        entry_pass = 0;
        step(1);
        chk("t1_strobe_one_cycle", {31'd0, car_entered}, 32'd0);
        step(5);

        // Only a uni space free: uni car admitted, non-uni denied once.
        is_vacated_space = 0; uni_is_vacated_space = 1; entry_req = 1; entry_is_uni = 1;
        step(1);
        chk("t2_uni_gate_open", {31'd0, entry_gate_open}, 32'd1);
        entry_pass = 1; entry_req = 0;
        step(1);
        chk("t2_uni_entered", {30'd0, car_entered, is_uni_car_enterd}, 32'd3);
        entry_pass = 0;
        step(6);
        entry_req = 1; entry_is_uni = 0;
        step(1);
        chk("t2_denied_pulse", {31'd0, entry_denied}, 32'd1);
        chk("t2_denied_gate_shut", {31'd0, entry_gate_open}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t2_no_second_deny", {30'd0, entry_denied, entry_gate_open}, 32'd0);
        end
        entry_req = 0;
        step(2);

        // Out of window: denied even with all vacancies; exit always allowed.
        timer = 32'd1250; is_vacated_space = 1; uni_is_vacated_space = 1;
        entry_req = 1; entry_is_uni = 1;
        step(1);
        chk("t3_late_denied", {30'd0, entry_denied, entry_gate_open}, 32'd2);
        entry_req = 0; exit_req = 1; exit_is_uni = 1;
        step(1);
        chk("t3_exit_gate_open", {31'd0, exit_gate_open}, 32'd1);
        exit_pass = 1; exit_req = 0;
        step(1);
        chk("t3_car_exited", {30'd0, car_exited, is_uni_car_exited}, 32'd3);
        chk("t3_exit_gate_dropped", {31'd0, exit_gate_open}, 32'd0);
        exit_pass = 0;
        step(1);
        chk("t3_exit_strobe_clear", {30'd0, car_exited, is_uni_car_exited}, 32'd0);
        step(4);

        // Window lower boundary: 479 denied.
        timer = 32'd479; entry_req = 1; entry_is_uni = 0;
        step(1);
        chk("t3_479_denied", {30'd0, entry_denied, entry_gate_open}, 32'd2);
        entry_req = 0;
        step(2);
`ifdef PARKING_GATE_STATS_EN
        chk("t3_denied_count_3", {16'd0, denied_count}, 32'd3);
`endif

        // Timeout: gate open for exactly 8 cycles with no pass, no strobe.
        timer = 32'd480; entry_req = 1; entry_is_uni = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk("t4_open_during_timeout", {30'd0, entry_gate_open, car_entered}, 32'd2);
        end
        step(1);
        chk("t4_closed_after_timeout", {30'd0, entry_gate_open, car_entered}, 32'd0);
        step(6);
        chk("t4_no_reopen_req_high", {31'd0, entry_gate_open}, 32'd0);
        entry_req = 0;
        step(1);
        entry_req = 1;
        step(1);
        chk("t4_reopen_after_hold", {31'd0, entry_gate_open}, 32'd1);

        // Window closing (1200) shuts an open gate without a strobe.
        timer = 32'd1200;
        step(1);
        chk("t4_window_close", {30'd0, entry_gate_open, car_entered}, 32'd0);
        entry_req = 0; timer = 32'd600;
        step(6);

        // Entry and exit pass on the same edge.
        entry_req = 1; entry_is_uni = 1; exit_req = 1; exit_is_uni = 0;
        step(1);
        chk("t5_both_open", {30'd0, entry_gate_open, exit_gate_open}, 32'd3);
        entry_pass = 1; exit_pass = 1; entry_req = 0; exit_req = 0;
        step(1);
        chk("t5_both_strobes", {28'd0, car_entered, is_uni_car_enterd, car_exited, is_uni_car_exited}, 32'hE);
        entry_pass = 0; exit_pass = 0;
        step(6);

        // Reset while open with a pass pending: immediate close, strobe lost.
        entry_req = 1; entry_is_uni = 0;
        step(1);
        chk("t5_open_before_rst", {31'd0, entry_gate_open}, 32'd1);
        entry_pass = 1;
        #2 rst = 1'b1;
        #1 chk("t5_rst_async_close", {31'd0, entry_gate_open}, 32'd0);
        step(1);
        chk("t5_rst_no_strobe", {30'd0, car_entered, entry_gate_open}, 32'd0);
`ifdef PARKING_GATE_STATS_EN
        chk("t5_rst_denied_count", {16'd0, denied_count}, 32'd0);
`endif
        entry_pass = 0;
        rst = 1'b0;
        step(1);
        chk("t5_held_req_after_rst", {31'd0, entry_gate_open}, 32'd1);
        entry_req = 0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter GATE_TIMEOUT, default 1000: clk cycles an open gate waits for a pass event before closing.
REQ-002 Parameter CLOSE_HOLD, default 4: minimum clk cycles a gate stays closed after a cycle, before it re-arms.
REQ-003 Ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- timer  in  32  minute of day, 0..1439.
- entry_req  in  1  car present on entry loop, level.
- entry_is_uni  in  1  university tag of entering car, valid while entry_req=1.
- entry_pass  in  1  car cleared entry barrier, level.
- exit_req  in  1  car present on exit loop, level.
- exit_is_uni  in  1  university tag of exiting car, valid while exit_req=1.
- exit_pass  in  1  car cleared exit barrier, level.
- uni_is_vacated_space  in  1  university space free, from occupancy counter.
- is_vacated_space  in  1  free-car space free, from occupancy counter.
- entry_gate_open  out  1  entry barrier up.
- exit_gate_open  out  1  exit barrier up.
- car_entered  out  1  one-cycle strobe to occupancy counter.
- is_uni_car_enterd  out  1  tag qualifying car_entered.
- car_exited  out  1  one-cycle strobe to occupancy counter.
- is_uni_car_exited  out  1  tag qualifying car_exited.
- entry_denied  out  1  one-cycle strobe, entry refused.

Function
REQ-004 Entry FSM states E_IDLE, E_OPEN, E_HOLD, E_DENY; exit FSM states X_IDLE, X_OPEN, X_HOLD; the two run independently.
REQ-005 Entry open window: 480 <= timer < 1200; outside it every entry request is denied.
REQ-006 E_IDLE, entry_req=1: admit if window open and (is_vacated_space, or entry_is_uni and uni_is_vacated_space); admit -> E_OPEN, latch entry_is_uni; else -> E_DENY with entry_denied=1 for exactly one cycle.
REQ-007 entry_gate_open = 1 exactly while in E_OPEN, registered, asserted the cycle after the admit decision.
REQ-008 E_OPEN, entry_pass=1: next cycle car_entered=1 for one cycle with is_uni_car_enterd = latched tag, -> E_HOLD.
REQ-009 E_OPEN, no pass for GATE_TIMEOUT cycles, or window closes: -> E_HOLD with no strobe.
REQ-010 E_HOLD: leave to E_IDLE only after CLOSE_HOLD cycles have elapsed and entry_req=0.
REQ-011 E_DENY: return to E_IDLE when entry_req=0; no re-evaluation or second entry_denied while entry_req stays high.
REQ-012 Exit FSM: X_IDLE, exit_req=1 -> X_OPEN unconditionally, any timer value, latch exit_is_uni.
REQ-013 X_OPEN, exit_pass=1: next cycle car_exited=1 for one cycle with is_uni_car_exited = latched tag, -> X_HOLD.
REQ-014 X_OPEN timeout: same as REQ-009, with no window condition; X_HOLD behaves as REQ-010 using exit_req.
REQ-015 car_entered and car_exited may assert in the same cycle; each is exactly one cycle wide, and each tag is 0 whenever its strobe is 0.
REQ-016 Timeout and hold counters are ceil(log2(max(GATE_TIMEOUT,CLOSE_HOLD)+1)) bits and clear on every state entry; pass and timeout in the same cycle resolve as pass.
REQ-017 Changes to the vacancy inputs after admission do not close an open gate.

Reset
REQ-018 rst=1 immediately forces E_IDLE and X_IDLE, closes both gates, zeroes all strobes, tags and counters, including mid-operation; a strobe pending at reset is lost.
REQ-019 After rst falls, a request already held high is evaluated on the first rising clk edge.

Configuration
REQ-020 With PARKING_GATE_STATS_EN defined: extra output port denied_count (16 bits) counts entry_denied pulses, saturates at 65535, and is cleared by rst; without the macro the port and its logic are absent, and behaviour is otherwise identical.

Verification
REQ-021 timer=600, is_vacated_space=1, non-uni entry_req -> gate open next cycle; entry_pass 3 cycles later -> car_entered=1, is_uni_car_enterd=0 for one cycle, gate drops.
REQ-022 timer=600, only uni_is_vacated_space=1: uni request -> admitted; non-uni request -> entry_denied one pulse, held entry_req gives no second pulse.
REQ-023 timer=1250, all vacancies 1 -> entry denied; exit_req with exit_is_uni=1 and exit_pass -> car_exited=1, is_uni_car_exited=1.
REQ-024 GATE_TIMEOUT=8, admitted entry, no pass -> gate closes after 8 cycles, no car_entered; re-request honoured only after CLOSE_HOLD cycles and entry_req low.
REQ-025 Entry pass and exit pass on the same edge -> car_entered and car_exited both high the next cycle; rst pulsed with gate open -> gate low immediately, no strobe.
REQ-026 With PARKING_GATE_STATS_EN defined: 3 denials -> denied_count=3; rst -> denied_count=0.
